img_fifo_drain: RTL and testbench

- Consumer side of the 784-entry, 8-bit grayscale image FIFO in the play_gif pipeline.
- On `start`, pops exactly one 28x28 frame from the FIFO, one byte at a time.
- Expands each byte to 12-bit RGB444 and writes it into the VGA frame buffer at its (x,y) position and linear address.
- Reports frame completion, or a stall error, to the GIF sequencer.

---
 rtl/img_fifo_drain_if.sv | 23 ++
 rtl/img_fifo_drain.sv | 118 +++++++++++
 tb/tb_img_fifo_drain.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/img_fifo_drain_if.sv
// FIFO read side and frame-buffer write side of the image drain.
// The drain connects to master; the FIFO/frame-buffer environment connects to slave.
interface img_fifo_drain_if;
  logic        fifo_empty;
  logic [9:0]  fifo_rptr;
  logic [7:0]  fifo_dataout;
  logic        fifo_rn;
  logic        fb_we;
  logic [9:0]  fb_addr;
  logic [4:0]  fb_x;
  logic [4:0]  fb_y;
  logic [11:0] fb_data;

  modport master (
    input  fifo_empty, fifo_rptr, fifo_dataout,
    output fifo_rn, fb_we, fb_addr, fb_x, fb_y, fb_data
  );

  modport slave (
    output fifo_empty, fifo_rptr, fifo_dataout,
    input  fifo_rn, fb_we, fb_addr, fb_x, fb_y, fb_data
  );
endinterface

// File: rtl/img_fifo_drain.sv
// Pops one IMG_W x IMG_H grayscale frame from the image FIFO and writes it as RGB444 into
// the frame buffer; one pixel per two cycles at best, fb_we two cycles after fifo_rn.
module img_fifo_drain #(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  img_fifo_drain_if.master  fifo,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        frame_cnt
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR} state_t;

  state_t          state, state_nxt;
  logic [9:0]      pix_cnt;
  logic [9:0]      rptr_q;
  logic [4:0]      x_cnt;
  logic [4:0]      y_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            popped;
  logic            last_pix;
  logic            tmo_hit;

  // A pop only counts once the FIFO read pointer has actually moved; a dropped pop leaves it put.
  assign popped   = (state == WAIT) && (fifo.fifo_rptr != rptr_q);
  assign last_pix = (pix_cnt == 10'(NPIX - 1));
  assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT - 1));

  assign fifo.fifo_rn = (state == REQ) && !fifo.fifo_empty;
  assign busy         = (state == REQ) || (state == WAIT);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = REQ;
      REQ: begin
        if (!fifo.fifo_empty) state_nxt = WAIT;
        else if (tmo_hit)     state_nxt = ERR;
      end
      WAIT: begin
        if (popped && last_pix) state_nxt = DONE;
        else                    state_nxt = REQ;
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_cnt      <= '0;
      rptr_q       <= '0;
      x_cnt        <= '0;
      y_cnt        <= '0;
      tmo_cnt      <= '0;
      frame_cnt    <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      fifo.fb_we   <= 1'b0;
      fifo.fb_addr <= '0;
      fifo.fb_x    <= '0;
      fifo.fb_y    <= '0;
      fifo.fb_data <= '0;
    end else begin
      fifo.fb_we <= 1'b0;
      done       <= (state == DONE);
      err        <= (state == ERR);
      case (state)
        IDLE: begin
          if (start) begin
            rptr_q  <= fifo.fifo_rptr;
            pix_cnt <= '0;
            x_cnt   <= '0;
            y_cnt   <= '0;
            tmo_cnt <= '0;
          end
        end
        REQ: begin
          if (!fifo.fifo_empty)  tmo_cnt <= '0;
          else if (!tmo_hit)     tmo_cnt <= tmo_cnt + TW'(1);
        end
        WAIT: begin
          if (popped) begin
            fifo.fb_we   <= 1'b1;
            fifo.fb_data <= {3{fifo.fifo_dataout[7:4]}};
            fifo.fb_addr <= pix_cnt;
            fifo.fb_x    <= x_cnt;
            fifo.fb_y    <= y_cnt;
            rptr_q       <= fifo.fifo_rptr;
            pix_cnt      <= pix_cnt + 10'd1;
            if (x_cnt == 5'(IMG_W - 1)) begin
              x_cnt <= '0;
              y_cnt <= y_cnt + 5'd1;
            end else begin
              x_cnt <= x_cnt + 5'd1;
            end
          end
        end
        DONE:    frame_cnt <= frame_cnt + 8'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_img_fifo_drain.sv
// Bench for img_fifo_drain: behavioural FIFO with write priority, pixel scoreboard,
// directed frame scenarios, and a small-geometry instance for frame counter wrap.
`timescale 1ns/1ps
module tb_img_fifo_drain;
  localparam int NPIX = 784;
  localparam int TMO  = 4096;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  img_fifo_drain_if ifc();
  logic       busy, done, err;
  logic [7:0] frame_cnt;

  img_fifo_drain #(.IMG_W(28), .IMG_H(28), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .fifo(ifc),
    .busy(busy), .done(done), .err(err), .frame_cnt(frame_cnt)
  );

  wire [44:0] outs = {ifc.fifo_rn, ifc.fb_we, ifc.fb_addr, ifc.fb_x, ifc.fb_y,
                      ifc.fb_data, busy, done, err, frame_cnt};

  // Small instance: always-full source, used to wrap frame_cnt quickly.
  img_fifo_drain_if sifc();
  logic       s_start = 1'b0;
  logic       s_busy, s_done, s_err;
  logic [7:0] s_frame_cnt;
  logic [9:0] s_rptr;

  img_fifo_drain #(.IMG_W(4), .IMG_H(2), .TIMEOUT(16)) sdut (
    .clk(clk), .reset(reset), .start(s_start), .fifo(sifc),
    .busy(s_busy), .done(s_done), .err(s_err), .frame_cnt(s_frame_cnt)
  );

  assign sifc.fifo_empty   = 1'b0;
  assign sifc.fifo_rptr    = s_rptr;
  assign sifc.fifo_dataout = s_rptr[7:0];
  always @(posedge clk) begin
    if (reset)              s_rptr <= '0;
    else if (sifc.fifo_rn)  s_rptr <= s_rptr + 10'd1;
  end

  // Image FIFO model: a write in the same cycle as a read request drops the pop.
  logic [7:0] mem [1024];
  logic [9:0] wptr, rptr, clr_base;
  logic [7:0] dout;
  int         cnt, seq;
  logic       wr_en = 1'b0;
  logic       clr   = 1'b1;
  wire        do_wr = wr_en && (cnt < NPIX);
  wire        do_rd = ifc.fifo_rn && !wr_en && (cnt != 0);

  assign ifc.fifo_empty   = (cnt == 0);
  assign ifc.fifo_rptr    = rptr;
  assign ifc.fifo_dataout = dout;

  initial clr_base = '0;

  always @(posedge clk) begin
    if (clr) begin
      wptr <= clr_base;
      rptr <= clr_base;
      cnt  <= 0;
      seq  <= 0;
    end else begin
      if (do_wr) begin
        mem[wptr] <= seq[7:0];
        wptr      <= wptr + 10'd1;
        seq       <= seq + 1;
      end
      if (do_rd) begin
        dout <= mem[rptr];
        rptr <= rptr + 10'd1;
      end
      cnt <= cnt + (do_wr ? 1 : 0) - (do_rd ? 1 : 0);
    end
  end

  int n_chk = 0, n_fail = 0;
  int wr_idx = 0, rn_cnt = 0, done_cnt = 0, err_cnt = 0;
  int cyc = 0, last_we_cyc = 0, err_cyc = 0;
  int s_we_cnt = 0, s_done_cnt = 0;
  logic [9:0]  log_addr [NPIX];
  logic [4:0]  log_x    [NPIX];
  logic [4:0]  log_y    [NPIX];
  logic [11:0] log_data [NPIX];
  int          hits     [NPIX];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pixel k must carry address k, its (x,y) and the expansion of byte k mod 256.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!reset) begin
      if (ifc.fifo_rn) begin
        rn_cnt++;
        check("rn_while_empty", ifc.fifo_empty, 0);
      end
      if (ifc.fb_we) begin
        check("pixel", {ifc.fb_addr, ifc.fb_x, ifc.fb_y, ifc.fb_data},
              {10'(wr_idx), 5'(wr_idx % 28), 5'(wr_idx / 28), {3{wr_idx[7:4]}}});
        if (wr_idx < NPIX) begin
          log_addr[wr_idx] = ifc.fb_addr;
          log_x[wr_idx]    = ifc.fb_x;
          log_y[wr_idx]    = ifc.fb_y;
          log_data[wr_idx] = ifc.fb_data;
        end
        if (int'(ifc.fb_addr) < NPIX) hits[ifc.fb_addr]++;
        last_we_cyc = cyc;
        wr_idx++;
      end
      if (done) done_cnt++;
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (sifc.fb_we) begin
        s_we_cnt++;
        check("small_addr", {sifc.fb_addr, sifc.fb_x < 5'd4, sifc.fb_y < 5'd2},
              {10'(sifc.fb_y * 4 + sifc.fb_x), 2'b11});
      end
      if (s_done) s_done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_clear(input logic [9:0] base);
    clr_base = base;
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic fifo_fill(input int n);
    wr_en = 1'b1;
    repeat (n) tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_log();
    wr_idx = 0;
    rn_cnt = 0;
    for (int i = 0; i < NPIX; i++) hits[i] = 0;
  endtask

  task automatic wait_done(input int base, input int budget);
    int t = 0;
    while (done_cnt == base && t < budget) begin tick(); t++; end
    check("wait_done", done_cnt > base, 1);
  endtask

  task automatic wait_err(input int base, input int budget);
    int t = 0;
    while (err_cnt == base && t < budget) begin tick(); t++; end
    check("wait_err", err_cnt > base, 1);
  endtask

  task automatic wait_pix(input int n, input int budget);
    int t = 0;
    while (wr_idx < n && t < budget) begin tick(); t++; end
    check("wait_pix", wr_idx >= n, 1);
  endtask

  function automatic int bad_hits();
    int b = 0;
    for (int i = 0; i < NPIX; i++) if (hits[i] != 1) b++;
    return b;
  endfunction

  typedef struct {
    int          k;
    logic [9:0]  addr;
    logic [4:0]  x;
    logic [4:0]  y;
    logic [11:0] data;
  } vec_t;

  vec_t vt [10];

  initial begin
    int t;
    vt[0] = '{0,   10'd0,   5'd0,  5'd0,  12'h000};
    vt[1] = '{5,   10'd5,   5'd5,  5'd0,  12'h000};
    vt[2] = '{27,  10'd27,  5'd27, 5'd0,  12'h111};
    vt[3] = '{28,  10'd28,  5'd0,  5'd1,  12'h111};
    vt[4] = '{100, 10'd100, 5'd16, 5'd3,  12'h666};
    vt[5] = '{167, 10'd167, 5'd27, 5'd5,  12'hAAA};
    vt[6] = '{255, 10'd255, 5'd3,  5'd9,  12'hFFF};
    vt[7] = '{256, 10'd256, 5'd4,  5'd9,  12'h000};
    vt[8] = '{500, 10'd500, 5'd24, 5'd17, 12'hFFF};
    vt[9] = '{783, 10'd783, 5'd27, 5'd27, 12'h000};

    repeat (3) tick();
    clr = 1'b0;
    @(negedge clk);
    check("reset_outputs", outs, 0);
    reset = 1'b0;
    tick();

    // Full frame from a preloaded FIFO.
    fifo_clear(10'd0); clear_log(); fifo_fill(NPIX); pulse_start();
    wait_done(0, 3000);
    check("t1_we_count", wr_idx, NPIX);
    check("t1_done_count", done_cnt, 1);
    check("t1_frame_cnt", frame_cnt, 1);
    check("t1_rn_count", rn_cnt, NPIX);
    check("t1_err_count", err_cnt, 0);
    check("t1_busy", busy, 0);
    check("t1_hits", bad_hits(), 0);
    for (int i = 0; i < 10; i++)
      check("tbl_pixel", {log_addr[vt[i].k], log_x[vt[i].k], log_y[vt[i].k], log_data[vt[i].k]},
            {vt[i].addr, vt[i].x, vt[i].y, vt[i].data});

    // Write collision on the pixel-5 request.
    fifo_clear(10'd0); clear_log(); fifo_fill(NPIX); pulse_start();
    t = 0;
    @(negedge clk);
    while (!(ifc.fb_we && ifc.fb_addr == 10'd4 && ifc.fifo_rn) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t2_collide_arm", t < 100, 1);
    wr_en = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t2_no_we_after_drop", ifc.fb_we, 0);
    wait_done(1, 3000);
    check("t2_we_count", wr_idx, NPIX);
    check("t2_rn_count", rn_cnt, NPIX + 1);
    check("t2_pix5_once", hits[5], 1);
    check("t2_hits", bad_hits(), 0);
    check("t2_frame_cnt", frame_cnt, 2);

    // Underflow stall, with FIFO pointers wrapping 1023 -> 0.
    fifo_clear(10'd1000); clear_log(); fifo_fill(100); pulse_start();
    wait_pix(100, 400);
    repeat (500) tick();
    check("t3_stall_state", {busy, 10'(wr_idx), 8'(err_cnt)}, {1'b1, 10'd100, 8'd0});
    fifo_fill(NPIX - 100);
    wait_done(2, 4000);
    check("t3_we_count", wr_idx, NPIX);
    check("t3_frame_cnt", frame_cnt, 3);
    check("t3_err_count", err_cnt, 0);
    check("t3_hits", bad_hits(), 0);

    // Timeout after 10 pixels.
    fifo_clear(10'd0); clear_log(); fifo_fill(10); pulse_start();
    wait_err(0, 6000);
    repeat (5) tick();
    check("t4_we_count", wr_idx, 10);
    check("t4_err_count", err_cnt, 1);
    check("t4_done_count", done_cnt, 3);
    check("t4_frame_cnt", frame_cnt, 3);
    check("t4_idle", busy, 0);
    check("t4_err_delay", err_cyc - last_we_cyc, TMO + 1);

    // Reset mid-frame, then a fresh frame.
    fifo_clear(10'd0); clear_log(); fifo_fill(NPIX); pulse_start();
    wait_pix(301, 1000);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_reset_outputs", outs, 0);
    tick();
    reset = 1'b0;
    check("t5_no_partial_done", done_cnt, 3);
    fifo_clear(10'd0); clear_log(); fifo_fill(NPIX); pulse_start();
    wait_done(3, 3000);
    check("t5_first_addr", log_addr[0], 0);
    check("t5_we_count", wr_idx, NPIX);
    check("t5_frame_cnt", frame_cnt, 1);
    check("t5_hits", bad_hits(), 0);

    // start while busy is ignored.
    fifo_clear(10'd0); clear_log(); fifo_fill(NPIX); pulse_start();
    wait_pix(50, 500);
    pulse_start();
    wait_done(4, 3000);
    repeat (20) tick();
    check("t6_we_count", wr_idx, NPIX);
    check("t6_done_count", done_cnt, 5);
    check("t6_frame_cnt", frame_cnt, 2);
    check("t6_idle", busy, 0);
    check("t6_hits", bad_hits(), 0);

    // 256 small frames wrap frame_cnt back to 0.
    for (int f = 0; f < 256; f++) begin
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      t = 0;
      while (s_done_cnt == f && t < 60) begin tick(); t++; end
      if (t >= 60) check("t7_frame_timeout", f, -1);
      if (f == 254) check("t7_frame_cnt_255", s_frame_cnt, 255);
    end
    check("t7_frame_cnt_wrap", s_frame_cnt, 0);
    check("t7_done_count", s_done_cnt, 256);
    check("t7_we_count", s_we_cnt, 256 * 8);
    check("t7_no_err", s_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
